// File: rtl/lgn_category_scorer_seq.sv
// Sequential popcount + arg-max over the LGN vote bits: one CHUNK-wide popcount per cycle,
// running best kept per class, result published with a one-cycle done pulse.
module lgn_category_scorer_seq #(
  parameter int CATEGORIES        = 10,
  parameter int BITS_PER_CATEGORY = 512,
  parameter int CHUNK             = 64,
  parameter int SUM_W             = $clog2(BITS_PER_CATEGORY) + 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [CATEGORIES*BITS_PER_CATEGORY-1:0] categories,
  output logic                                    busy,
  output logic                                    done,
  output logic [3:0]                              out_index,
  output logic [SUM_W-1:0]                        out_value,
  output logic                                    dbg_state
);

  localparam int NCH  = BITS_PER_CATEGORY / CHUNK;
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PC_W = $clog2(CHUNK) + 1;

  if (BITS_PER_CATEGORY % CHUNK != 0) begin : g_bad_chunk
    $error("CHUNK must divide BITS_PER_CATEGORY");
  end
  if (CATEGORIES > 16) begin : g_bad_cat
    $error("CATEGORIES must be at most 16");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  logic [3:0]        cat;
  logic [CH_W-1:0]   chunk;
  logic [SUM_W-1:0]  acc;
  logic [SUM_W-1:0]  best_val;
  logic [3:0]        best_idx;

  logic [31:0]       base;
  logic [CHUNK-1:0]  slice;
  logic [PC_W-1:0]   pc;
  logic [SUM_W-1:0]  cand;
  logic              take;
  logic [SUM_W-1:0]  win_val;
  logic [3:0]        win_idx;
  logic              last_chunk;
  logic              last_cat;

  assign dbg_state = state;

  always_comb begin
    base  = 32'(cat) * 32'(BITS_PER_CATEGORY) + 32'(chunk) * 32'(CHUNK);
    slice = categories[base +: CHUNK];
    pc    = '0;
    for (int i = 0; i < CHUNK; i++) pc = pc + PC_W'(slice[i]);
    cand       = acc + SUM_W'(pc);
    // Strict > keeps the lowest index on ties; class 0 always seeds the best.
    take       = (cat == 4'd0) || (cand > best_val);
    win_val    = take ? cand : best_val;
    win_idx    = take ? cat : best_idx;
    last_chunk = (chunk == CH_W'(NCH - 1));
    last_cat   = (cat == 4'(CATEGORIES - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_index <= '0;
      out_value <= '0;
      cat       <= '0;
      chunk     <= '0;
      acc       <= '0;
      best_val  <= '0;
      best_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cat      <= '0;
            chunk    <= '0;
            acc      <= '0;
            best_val <= '0;
            best_idx <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (!last_chunk) begin
            acc   <= cand;
            chunk <= chunk + 1'b1;
          end else begin
            best_val <= win_val;
            best_idx <= win_idx;
            acc      <= '0;
            chunk    <= '0;
            if (last_cat) begin
              out_index <= win_idx;
              out_value <= win_val;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              cat <= cat + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lgn_category_scorer_seq.sv
// Directed bench for lgn_category_scorer_seq: hand-computed winners, latency, tie,
// full-count width, ignored re-start, back-to-back start and mid-run reset.
module tb_lgn_category_scorer_seq;

  localparam int CATS  = 10;
  localparam int BPC   = 512;
  localparam int SUM_W = 10;
  localparam int LAT   = 80;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [CATS*BPC-1:0]   categories;
  logic                  busy;
  logic                  done;
  logic [3:0]            out_index;
  logic [SUM_W-1:0]      out_value;
  logic                  dbg_state;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  lgn_category_scorer_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .categories (categories),
    .busy       (busy),
    .done       (done),
    .out_index  (out_index),
    .out_value  (out_value),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sets n distinct bits of class c; an odd stride spreads them over every chunk.
  task automatic set_class(input int c, input int n, input int stride);
    for (int k = 0; k < n; k++) categories[c*BPC + ((k*stride) % BPC)] = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done; ra/rb re-pulse start mid-run,
  // chain leaves start high in the done cycle.
  task automatic wait_done(input string tag, input int ra, input int rb, input bit chain,
                           input int exp_idx, input int exp_val);
    int n = 0;
    bit busy_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      n++;
      start = (n == ra) || (n == rb);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    start = chain;
    chk({tag, "_latency"}, n, LAT);
    chk({tag, "_busy_held"}, busy_ok, 1);
    chk({tag, "_busy_low_at_done"}, busy, 0);
    chk({tag, "_index"}, out_index, exp_idx);
    chk({tag, "_value"}, out_value, exp_val);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    categories = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_index", out_index, 0);
    chk("reset_value", out_value, 0);
    chk("reset_state", dbg_state, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: all zero
    pulse_start();
    wait_done("zero", -1, -1, 1'b0, 0, 0);
    @(posedge clk); #1;
    chk("zero_done_one_cycle", done, 0);

    // 2: class 7 has 300 votes
    categories = '0;
    set_class(7, 300, 3);
    pulse_start();
    wait_done("c7", -1, -1, 1'b0, 7, 300);

    // 3: tie between classes 2 and 5
    categories = '0;
    set_class(0, 99, 5);
    set_class(2, 100, 7);
    set_class(5, 100, 11);
    set_class(9, 50, 13);
    pulse_start();
    wait_done("tie", -1, -1, 1'b0, 2, 100);

    // 4: full class must read 512
    categories = '0;
    set_class(0, 511, 1);
    set_class(9, 512, 1);
    pulse_start();
    wait_done("full", -1, -1, 1'b0, 9, 512);

    // 5: ignored re-starts, then a start in the done cycle
    pulse_start();
    wait_done("restart", 10, 40, 1'b1, 9, 512);
    categories = '0;
    set_class(3, 200, 9);
    set_class(8, 199, 3);
    @(posedge clk); #1;
    start = 1'b0;
    chk("chain_done_dropped", done, 0);
    chk("chain_busy", busy, 1);
    chk("chain_index_held", out_index, 9);
    chk("chain_value_held", out_value, 512);
    wait_done("chain", -1, -1, 1'b0, 3, 200);

    // 6: reset aborts a run
    pulse_start();
    repeat (30) @(posedge clk);
    #1;
    chk("midrun_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_index", out_index, 0);
    chk("abort_value", out_value, 0);
    chk("abort_state", dbg_state, 0);
    categories = '0;
    set_class(1, 63, 17);
    set_class(4, 64, 21);
    pulse_start();
    wait_done("after_rst", -1, -1, 1'b0, 4, 64);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
